// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, immediate mux, single-cycle ALU, destination select,
// and an iterative 32-step multiply/divide unit with HI/LO that stalls the pipe while busy.
module exe_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data11,
  input  logic [WIDTH-1:0] data22,
  input  logic [WIDTH-1:0] signImmE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       RdE,
  input  logic [3:0]       ALUControlE,
  input  logic             ALUSrcE,
  input  logic             regDstE,
  input  logic [2:0]       mdOpE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [WIDTH-1:0] resultW,
  input  logic             flushE,
  output logic [WIDTH-1:0] ALUOutE,
  output logic [WIDTH-1:0] writeDataE,
  output logic [4:0]       writeRegE,
  output logic             zeroE,
  output logic             mdBusyE
);

  localparam int unsigned CntW    = $clog2(MD_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(MD_CYCLES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_res;
  logic [4:0]       shamt;

  always_comb begin
    unique case (ForwardAE)
      2'b00:   src_a = data11;
      2'b01:   src_a = resultW;
      2'b10:   src_a = ALUOutM;
      default: src_a = '0;
    endcase
    unique case (ForwardBE)
      2'b00:   fwd_b = data22;
      2'b01:   fwd_b = resultW;
      2'b10:   fwd_b = ALUOutM;
      default: fwd_b = '0;
    endcase
  end

  assign src_b      = ALUSrcE ? signImmE : fwd_b;
  assign shamt      = signImmE[10:6];
  assign writeDataE = fwd_b;
  assign writeRegE  = regDstE ? RdE : RtE;

  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      4'b0000: alu_res = src_a & src_b;
      4'b0001: alu_res = src_a | src_b;
      4'b0010: alu_res = src_a + src_b;
      4'b0011: alu_res = src_a ^ src_b;
      4'b0110: alu_res = src_a - src_b;
      4'b1100: alu_res = ~(src_a | src_b);
      4'b0100: alu_res = src_b << shamt;
      4'b0101: alu_res = src_b >> shamt;
      4'b0111: alu_res[0] = $signed(src_a) < $signed(src_b);
      4'b1000: alu_res[0] = src_a < src_b;
      default: alu_res = '0;
    endcase
  end

  // Multiply/divide unit state
  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               negr_q, negr_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic             md_start, md_signed, md_div, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign md_start  = (mdOpE == 3'b001 || mdOpE == 3'b010 || mdOpE == 3'b011 ||
                      mdOpE == 3'b100) && !flushE;
  assign md_signed = (mdOpE == 3'b001) || (mdOpE == 3'b011);
  assign md_div    = (mdOpE == 3'b011) || (mdOpE == 3'b100);
  assign a_neg     = md_signed && src_a[WIDTH-1];
  assign b_neg     = md_signed && fwd_b[WIDTH-1];
  assign mag_a     = a_neg ? -src_a : src_a;
  assign mag_b     = b_neg ? -fwd_b : fwd_b;

  // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] mul_next, div_next, step_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opb_q}) : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
    step_next = div_q ? div_next : mul_next;
    prod_fix  = neg_q ? -step_next : step_next;
    quo_fix   = neg_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
    rem_fix   = negr_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    div_d   = div_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        if (md_start) begin
          state_d = StRun;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, mag_a};
          opb_d   = mag_b;
          div_d   = md_div;
          neg_d   = a_neg ^ b_neg;
          negr_d  = a_neg;
        end
      end
      StRun: begin
        if (flushE) begin
          state_d = StIdle;
        end else begin
          acc_d = step_next;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StDone;
            if (div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end
          end
        end
      end
      // The finished instruction is still in EX here; leaving unconditionally stops a re-issue.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mdBusyE = !rst && ((state_q == StIdle && md_start) || state_q == StRun);

  always_comb begin
    if (mdOpE == 3'b101)      ALUOutE = hi_q;
    else if (mdOpE == 3'b110) ALUOutE = lo_q;
    else                      ALUOutE = alu_res;
  end

  assign zeroE = (ALUOutE == '0);

endmodule
